// File: rtl/bus1to2_pkg.sv
// ============================================================================
// Module : bus1to2_pkg
// Brief  : Shared widths, FSM encoding and region decode helper for bus1to2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus1to2_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_A0   = 2'd1;
    localparam logic [1:0] ST_A1   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        A0   = ST_A0,
        A1   = ST_A1,
        RESP = ST_RESP
    } state_e;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    function automatic logic region_hit(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] mask,
        input logic [ADDR_W-1:0] base
    );
        return ((addr & mask) == base);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus1to2_if.sv
// ============================================================================
// Module : bus1to2_if
// Brief  : valid/ready memory-style bus with master and slave views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus1to2_if;
    import bus1to2_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

`default_nettype wire

// File: rtl/bus1to2_bus_timeout.sv
// ============================================================================
// Module : bus_timeout
// Brief  : Loadable down-counter flagging expiry of a slave wait window.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  wire  clk,
    input  wire  resetn,
    input  wire  clr,
    input  wire  en,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_enabled
            localparam int              CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            // Loading TIMEOUT-1 makes expiry land on the TIMEOUT-th wait cycle.
            always_comb begin
                count_d = count_q;
                if (clr) begin
                    count_d = LOAD;
                end else if (en && (count_q != '0)) begin
                    count_d = count_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired = (count_q == '0);
        end else begin : g_disabled
            assign expired = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bus1to2.sv
// ============================================================================
// Module : bus1to2
// Brief  : One-master, two-slave address-decoding splitter with error response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus1to2
    import bus1to2_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S0_MASK   = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE   = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] S1_MASK   = 32'hF000_0000,
    parameter int                TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
    input  wire               clk,
    input  wire               resetn,
    bus1to2_if.slave          m,
    bus1to2_if.master         s0,
    bus1to2_if.master         s1,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr
);

    state_e            state_q,    state_d;
    logic              m_ready_q,  m_ready_d;
    logic [DATA_W-1:0] m_rdata_q,  m_rdata_d;
    logic              bus_err_q,  bus_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              s0_valid_q, s0_valid_d;
    logic [ADDR_W-1:0] s0_addr_q,  s0_addr_d;
    logic [DATA_W-1:0] s0_wdata_q, s0_wdata_d;
    logic [STRB_W-1:0] s0_wstrb_q, s0_wstrb_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
    logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;
    logic [STRB_W-1:0] s1_wstrb_q, s1_wstrb_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        m_ready_d  = 1'b0;
        bus_err_d  = 1'b0;
        m_rdata_d  = m_rdata_q;
        err_addr_d = err_addr_q;
        s0_valid_d = s0_valid_q;
        s0_addr_d  = s0_addr_q;
        s0_wdata_d = s0_wdata_q;
        s0_wstrb_d = s0_wstrb_q;
        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s1_wdata_d = s1_wdata_q;
        s1_wstrb_d = s1_wstrb_q;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (m.valid) begin
                    // S0 is tested first so it wins where the regions overlap.
                    if (region_hit(m.addr, S0_MASK, S0_BASE)) begin
                        s0_valid_d = 1'b1;
                        s0_addr_d  = m.addr;
                        s0_wdata_d = m.wdata;
                        s0_wstrb_d = m.wstrb;
                        tmo_clr    = 1'b1;
                        state_d    = A0;
                    end else if (region_hit(m.addr, S1_MASK, S1_BASE)) begin
                        s1_valid_d = 1'b1;
                        s1_addr_d  = m.addr;
                        s1_wdata_d = m.wdata;
                        s1_wstrb_d = m.wstrb;
                        tmo_clr    = 1'b1;
                        state_d    = A1;
                    end else begin
                        m_ready_d  = 1'b1;
                        bus_err_d  = 1'b1;
                        m_rdata_d  = ERR_RDATA;
                        err_addr_d = m.addr;
                        state_d    = RESP;
                    end
                end
            end
            A0: begin
                if (s0.ready) begin
                    s0_valid_d = 1'b0;
                    m_ready_d  = 1'b1;
                    m_rdata_d  = s0.rdata;
                    state_d    = RESP;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expired) begin
                        s0_valid_d = 1'b0;
                        m_ready_d  = 1'b1;
                        bus_err_d  = 1'b1;
                        m_rdata_d  = ERR_RDATA;
                        err_addr_d = s0_addr_q;
                        state_d    = RESP;
                    end
                end
            end
            A1: begin
                if (s1.ready) begin
                    s1_valid_d = 1'b0;
                    m_ready_d  = 1'b1;
                    m_rdata_d  = s1.rdata;
                    state_d    = RESP;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expired) begin
                        s1_valid_d = 1'b0;
                        m_ready_d  = 1'b1;
                        bus_err_d  = 1'b1;
                        m_rdata_d  = ERR_RDATA;
                        err_addr_d = s1_addr_q;
                        state_d    = RESP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            m_ready_q  <= 1'b0;
            m_rdata_q  <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
            s0_valid_q <= 1'b0;
            s0_addr_q  <= '0;
            s0_wdata_q <= '0;
            s0_wstrb_q <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_wdata_q <= '0;
            s1_wstrb_q <= '0;
        end else begin
            state_q    <= state_d;
            m_ready_q  <= m_ready_d;
            m_rdata_q  <= m_rdata_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
            s0_valid_q <= s0_valid_d;
            s0_addr_q  <= s0_addr_d;
            s0_wdata_q <= s0_wdata_d;
            s0_wstrb_q <= s0_wstrb_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_wdata_q <= s1_wdata_d;
            s1_wstrb_q <= s1_wstrb_d;
        end
    end

    assign m.ready   = m_ready_q;
    assign m.rdata   = m_rdata_q;
    assign s0.valid  = s0_valid_q;
    assign s0.addr   = s0_addr_q;
    assign s0.wdata  = s0_wdata_q;
    assign s0.wstrb  = s0_wstrb_q;
    assign s1.valid  = s1_valid_q;
    assign s1.addr   = s1_addr_q;
    assign s1.wdata  = s1_wdata_q;
    assign s1.wstrb  = s1_wstrb_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_bus1to2.sv
// ============================================================================
// Module : tb_bus1to2
// Brief  : Directed vector bench for the bus1to2 splitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus1to2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          tgt;       // 0 = S0, 1 = S1, 2 = unmapped
        int          wait_n;    // valid cycles before the slave answers
        logic [31:0] srdata;
        bit          stray;     // hold the other slave's ready high
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_vcyc;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        bus_err;
    logic [31:0] err_addr;

    int          n_vec;
    int          n_cmp;
    int          n_fail;
    logic [31:0] last_err;

    bus1to2_if m_if ();
    bus1to2_if s0_if ();
    bus1to2_if s1_if ();

    bus1to2 #(
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m        (m_if),
        .s0       (s0_if),
        .s1       (s1_if),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int vcyc;
        bit done;
        @(negedge clk);
        chk("idle_m_ready", {31'd0, m_if.ready}, 32'd0);
        chk("idle_bus_err", {31'd0, bus_err}, 32'd0);
        m_if.valid = 1'b1;
        m_if.addr  = v.addr;
        m_if.wdata = v.wdata;
        m_if.wstrb = v.wstrb;
        lat  = 0;
        vcyc = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            s0_if.ready = v.stray && (v.tgt == 1);
            s1_if.ready = v.stray && (v.tgt == 0);
            s0_if.rdata = 32'hFFFF_0000;
            s1_if.rdata = 32'hFFFF_0001;
            if (v.tgt != 0) chk("s0_valid_off", {31'd0, s0_if.valid}, 32'd0);
            if (v.tgt != 1) chk("s1_valid_off", {31'd0, s1_if.valid}, 32'd0);
            if (v.tgt == 0 && s0_if.valid) begin
                vcyc++;
                chk("s0_addr", s0_if.addr, v.addr);
                chk("s0_wdata", s0_if.wdata, v.wdata);
                chk("s0_wstrb", {28'd0, s0_if.wstrb}, {28'd0, v.wstrb});
                if (vcyc > v.wait_n) begin
                    s0_if.ready = 1'b1;
                    s0_if.rdata = v.srdata;
                end
            end
            if (v.tgt == 1 && s1_if.valid) begin
                vcyc++;
                chk("s1_addr", s1_if.addr, v.addr);
                chk("s1_wdata", s1_if.wdata, v.wdata);
                chk("s1_wstrb", {28'd0, s1_if.wstrb}, {28'd0, v.wstrb});
                if (vcyc > v.wait_n) begin
                    s1_if.ready = 1'b1;
                    s1_if.rdata = v.srdata;
                end
            end
            if (m_if.ready) begin
                done = 1'b1;
                chk("latency", lat, v.exp_lat);
                chk("valid_cycles", vcyc, v.exp_vcyc);
                chk("m_rdata", m_if.rdata, v.exp_rdata);
                chk("bus_err", {31'd0, bus_err}, {31'd0, v.exp_err});
                if (v.exp_err) last_err = v.addr;
                chk("err_addr", err_addr, last_err);
                m_if.valid = 1'b0;
            end else begin
                chk("bus_err_quiet", {31'd0, bus_err}, 32'd0);
            end
        end
        s0_if.ready = 1'b0;
        s1_if.ready = 1'b0;
        chk("m_ready_seen", {31'd0, done}, 32'd1);
        n_vec++;
    endtask

    vec_t vecs[10];

    initial begin
        n_vec    = 0;
        n_cmp    = 0;
        n_fail   = 0;
        last_err = 32'h0;

        //            addr          wdata         strb  tgt wait srdata        stray exp_rdata     err lat vcyc
        vecs[0] = '{32'h0000_0100, 32'h0000_0000, 4'h0, 0, 0,  32'h1234_5678, 0, 32'h1234_5678, 0,  2,  1};
        vecs[1] = '{32'h1000_0004, 32'hA5A5_0F0F, 4'h3, 1, 3,  32'h5555_AAAA, 0, 32'h5555_AAAA, 0,  5,  4};
        vecs[2] = '{32'h2000_0000, 32'h0000_0000, 4'h0, 2, 0,  32'h0,         0, 32'hDEAD_BEEF, 1,  1,  0};
        vecs[3] = '{32'h0000_0040, 32'h0000_0000, 4'h0, 0, 99, 32'h0,         0, 32'hDEAD_BEEF, 1, 17, 16};
        vecs[4] = '{32'h0FFF_FFFC, 32'h1357_9BDF, 4'hF, 0, 1,  32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0,  3,  2};
        vecs[5] = '{32'h1FFF_FFFC, 32'h0000_0000, 4'h0, 1, 0,  32'hCAFE_0001, 1, 32'hCAFE_0001, 0,  2,  1};
        vecs[6] = '{32'hF000_0000, 32'h0000_0000, 4'h0, 2, 0,  32'h0,         0, 32'hDEAD_BEEF, 1,  1,  0};
        vecs[7] = '{32'h1000_0010, 32'h0000_0000, 4'h0, 1, 99, 32'h0,         0, 32'hDEAD_BEEF, 1, 17, 16};
        vecs[8] = '{32'h0000_0200, 32'h0000_0000, 4'h0, 0, 15, 32'h7777_8888, 1, 32'h7777_8888, 0, 17, 16};
        vecs[9] = '{32'h1000_0000, 32'h0F0F_0F0F, 4'h8, 1, 2,  32'h0000_0001, 0, 32'h0000_0001, 0,  4,  3};

        resetn      = 1'b1;
        m_if.valid  = 1'b0;
        m_if.addr   = 32'h0;
        m_if.wdata  = 32'h0;
        m_if.wstrb  = 4'h0;
        s0_if.ready = 1'b0;
        s0_if.rdata = 32'h0;
        s1_if.ready = 1'b0;
        s1_if.rdata = 32'h0;
        #1 resetn = 1'b0;
        #1;
        chk("rst_m_ready", {31'd0, m_if.ready}, 32'd0);
        chk("rst_m_rdata", m_if.rdata, 32'd0);
        chk("rst_s0_valid", {31'd0, s0_if.valid}, 32'd0);
        chk("rst_s1_valid", {31'd0, s1_if.valid}, 32'd0);
        chk("rst_s0_addr", s0_if.addr, 32'd0);
        chk("rst_s1_wdata", s1_if.wdata, 32'd0);
        chk("rst_s1_wstrb", {28'd0, s1_if.wstrb}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Table vectors are issued back to back, each in the IDLE cycle after
        // the previous completion.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Abandon an S1 transaction with an asynchronous reset.
        @(negedge clk);
        m_if.valid = 1'b1;
        m_if.addr  = 32'h1000_0020;
        m_if.wdata = 32'h1111_2222;
        m_if.wstrb = 4'hF;
        @(negedge clk);
        chk("mid_s1_valid_before", {31'd0, s1_if.valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_s1_valid", {31'd0, s1_if.valid}, 32'd0);
        chk("mid_s1_addr", s1_if.addr, 32'd0);
        chk("mid_m_ready", {31'd0, m_if.ready}, 32'd0);
        chk("mid_err_addr", err_addr, 32'd0);
        chk("mid_m_rdata", m_if.rdata, 32'd0);
        last_err   = 32'h0;
        m_if.valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_m_ready_held", {31'd0, m_if.ready}, 32'd0);
        resetn = 1'b1;
        run_vec('{32'h0000_0008, 32'h0, 4'h0, 0, 0, 32'h0000_ABCD, 0, 32'h0000_ABCD, 0, 2, 1});

        // Explicit back-to-back pair: S0 read then S1 read in the next IDLE cycle.
        run_vec('{32'h0000_0010, 32'h0, 4'h0, 0, 1, 32'h2468_ACE0, 0, 32'h2468_ACE0, 0, 3, 2});
        run_vec('{32'h1000_0000, 32'h0, 4'h0, 1, 0, 32'h1357_0000, 0, 32'h1357_0000, 0, 2, 1});
        @(negedge clk);
        chk("final_m_ready_low", {31'd0, m_if.ready}, 32'd0);
        chk("final_err_addr_held", err_addr, last_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
